// File: rtl/alt_vipvfr131_common_output_sequencer_pkg.sv
// Shared types for the VIP output sequencer: FSM states, dimension/interlace types, settle-counter width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alt_vipvfr131_common_output_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SEND_CTRL = 3'd1,
        WAIT_CTRL = 3'd2,
        STREAM    = 3'd3,
        EOV       = 3'd4
    } seq_state_e;

    typedef logic [15:0] dim_t;
    typedef logic [3:0]  ilace_t;

    // Wide enough for a settle count of up to 15 cycles.
    localparam int SETTLE_W = 4;

    // A frame with either dimension zero carries no pixels and is refused.
    function automatic logic dim_is_zero(input dim_t w, input dim_t h);
        return (w == '0) || (h == '0);
    endfunction

endpackage

// File: rtl/alt_vipvfr131_common_output_sequencer_if.sv
// Bundle of config, pixel-source, encoder and flow-control-output signals around the sequencer.
// Latency: n/a (wires only).
// Backpressure: pix_valid/pix_ready upstream, write/stall_out downstream.
// Modports: slave = the sequencer's view, master = the surrounding environment's view.
interface alt_vipvfr131_common_output_sequencer_if #(
    parameter int DATA_W = 24
) ();
    import alt_vipvfr131_common_output_sequencer_pkg::*;

    // configuration handshake
    logic              cfg_valid;
    logic              cfg_ready;
    dim_t              cfg_width;
    dim_t              cfg_height;
    ilace_t            cfg_interlaced;
    logic              cfg_error;
    logic              stop;
    // upstream pixel source
    logic [DATA_W-1:0] pix_data;
    logic              pix_valid;
    logic              pix_ready;
    // toward the flow-control output
    logic [DATA_W-1:0] data_out;
    dim_t              width_out;
    dim_t              height_out;
    ilace_t            interlaced_out;
    logic              vip_ctrl_valid_out;
    logic              end_of_video_out;
    logic              write;
    logic              stall_out;
    logic              encoder_vip_ctrl_busy;
    // status
    logic              busy;
    logic              frame_done;

    modport slave (
        input  cfg_valid, cfg_width, cfg_height, cfg_interlaced, stop,
               pix_data, pix_valid, stall_out, encoder_vip_ctrl_busy,
        output cfg_ready, cfg_error, pix_ready, data_out, width_out, height_out,
               interlaced_out, vip_ctrl_valid_out, end_of_video_out, write,
               busy, frame_done
    );

    modport master (
        output cfg_valid, cfg_width, cfg_height, cfg_interlaced, stop,
               pix_data, pix_valid, stall_out, encoder_vip_ctrl_busy,
        input  cfg_ready, cfg_error, pix_ready, data_out, width_out, height_out,
               interlaced_out, vip_ctrl_valid_out, end_of_video_out, write,
               busy, frame_done
    );

endinterface

// File: rtl/alt_vipvfr131_common_xy_counter.sv
// Raster x/y position counter for one frame; flags the last pixel of a line and the last beat of the frame.
// Latency: flags are combinational from the current count; the count updates one cycle after en_i.
// Backpressure: none; the count holds whenever en_i is low.
// Ports: clk/rst, clear_i (zero both counters), en_i (advance one beat), width_i/height_i (frame size limits),
//        last_pixel_o (x at width-1), last_frame_beat_o (x at width-1 and y at height-1).
module alt_vipvfr131_common_xy_counter
    import alt_vipvfr131_common_output_sequencer_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic en_i,
    input  dim_t width_i,
    input  dim_t height_i,
    output logic last_pixel_o,
    output logic last_frame_beat_o
);

    dim_t x_q, x_d;
    dim_t y_q, y_d;

    // Limits are never zero here: zero-sized frames are refused before streaming starts.
    assign last_pixel_o      = (x_q == (width_i - 16'd1));
    assign last_frame_beat_o = last_pixel_o && (y_q == (height_i - 16'd1));

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clear_i) begin
            x_d = '0;
            y_d = '0;
        end else if (en_i) begin
            if (last_pixel_o) begin
                x_d = '0;
                y_d = y_q + 16'd1;
            end else begin
                x_d = x_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

endmodule

// File: rtl/alt_vipvfr131_common_output_sequencer.sv
// Frame sequencer: accept a config, request one control packet, then stream width*height pixel beats.
// Latency: pixel path is combinational (pix_data -> data_out, write same cycle); control is one FSM step per cycle.
// Backpressure: stall_out drops pix_ready and write in the same cycle; the beat count holds while stalled.
// Ports: clk/rst plain; bus (slave modport) carries cfg handshake, stop, pixel source, encoder busy,
//        flow-control outputs (data_out, write, vip_ctrl_valid_out, end_of_video_out, latched config) and status.
module alt_vipvfr131_common_output_sequencer
    import alt_vipvfr131_common_output_sequencer_pkg::*;
#(
    parameter int BITS_PER_SYMBOL    = 8,
    parameter int SYMBOLS_PER_BEAT   = 3,
    parameter int CTRL_SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    alt_vipvfr131_common_output_sequencer_if.slave bus
);

    localparam int                  DATA_W      = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT;
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(CTRL_SETTLE_CYCLES - 1);

    seq_state_e          state_q, state_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic                stop_pending_q, stop_pending_d;
    dim_t                width_q, width_d;
    dim_t                height_q, height_d;
    ilace_t              ilace_q, ilace_d;

    logic              cfg_error_c;
    logic              stop_req;
    logic              in_stream;
    logic              fire;
    logic              last_pixel;
    logic              last_frame_beat;
    logic [DATA_W-1:0] data_mux;

    // A stop arriving in the same cycle as a frame boundary counts as if it had been latched earlier.
    assign stop_req  = stop_pending_q | bus.stop;
    assign in_stream = (state_q == STREAM);
    assign fire      = in_stream & bus.pix_valid & ~bus.stall_out;

    alt_vipvfr131_common_xy_counter u_xy (
        .clk               (clk),
        .rst               (rst),
        .clear_i           (state_q == WAIT_CTRL),
        .en_i              (fire),
        .width_i           (width_q),
        .height_i          (height_q),
        .last_pixel_o      (last_pixel),
        .last_frame_beat_o (last_frame_beat)
    );

    always_comb begin
        state_d     = state_q;
        settle_d    = settle_q;
        width_d     = width_q;
        height_d    = height_q;
        ilace_d     = ilace_q;
        cfg_error_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (stop_req) begin
                    state_d = EOV;
                end else if (bus.cfg_valid) begin
                    if (dim_is_zero(bus.cfg_width, bus.cfg_height)) begin
                        cfg_error_c = 1'b1;
                    end else begin
                        width_d  = bus.cfg_width;
                        height_d = bus.cfg_height;
                        ilace_d  = bus.cfg_interlaced;
                        state_d  = SEND_CTRL;
                    end
                end
            end
            SEND_CTRL: begin
                state_d  = WAIT_CTRL;
                settle_d = SETTLE_LOAD;
            end
            WAIT_CTRL: begin
                // The encoder's busy flag lags the request, so it is ignored until the settle count expires.
                if (settle_q != '0) begin
                    settle_d = settle_q - 1'b1;
                end else if (!bus.encoder_vip_ctrl_busy) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (fire && last_frame_beat) begin
                    state_d = stop_req ? EOV : IDLE;
                end
            end
            EOV: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The pending stop is consumed by the EOV it triggers; a stop seen during EOV arms the next one.
    assign stop_pending_d = ((state_d == EOV) && (state_q != EOV)) ? 1'b0 : stop_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            settle_q       <= '0;
            stop_pending_q <= 1'b0;
            width_q        <= '0;
            height_q       <= '0;
            ilace_q        <= '0;
        end else begin
            state_q        <= state_d;
            settle_q       <= settle_d;
            stop_pending_q <= stop_pending_d;
            width_q        <= width_d;
            height_q       <= height_d;
            ilace_q        <= ilace_d;
        end
    end

    assign data_mux = in_stream ? bus.pix_data : '0;

    assign bus.cfg_ready          = (state_q == IDLE);
    assign bus.cfg_error          = cfg_error_c;
    assign bus.pix_ready          = in_stream & ~bus.stall_out;
    assign bus.write              = fire;
    assign bus.data_out           = data_mux;
    assign bus.width_out          = width_q;
    assign bus.height_out         = height_q;
    assign bus.interlaced_out     = ilace_q;
    assign bus.vip_ctrl_valid_out = (state_q == SEND_CTRL);
    assign bus.end_of_video_out   = (state_q == EOV);
    assign bus.busy               = (state_q != IDLE);
    assign bus.frame_done         = fire & last_frame_beat;

endmodule

// File: tb/tb_alt_vipvfr131_common_output_sequencer.sv
// Directed bench for the output sequencer: reset, plain frame, stalls, encoder busy, stop, bad config, mid-frame reset.
// Latency: n/a.
// Backpressure: stall_out driven from a per-cycle pattern inside watch().
module tb_alt_vipvfr131_common_output_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    alt_vipvfr131_common_output_sequencer_if #(.DATA_W(24)) bus ();

    alt_vipvfr131_common_output_sequencer #(
        .BITS_PER_SYMBOL    (8),
        .SYMBOLS_PER_BEAT   (3),
        .CTRL_SETTLE_CYCLES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    localparam logic [23:0] BASE = 24'hA50000;

    int tests = 0;
    int fails = 0;

    // per-watch observations
    int          beats, ctrl_cnt, ctrl_cyc, first_wr, fd_cnt, fd_cyc, fd_bad;
    int          eov_cnt, eov_cyc, wr_stall, rdy_stall, idle_nz, busy_cnt, pix_idx;
    logic        last_busy, last_rdy;
    logic [23:0] got[$];

    // Called and returns at a negedge. Drives one input pattern per cycle, samples 1 time unit later.
    task automatic watch(input int ncyc, input int stall_mode, input int busy_last, input int stop_cyc);
        beats = 0; ctrl_cnt = 0; ctrl_cyc = -1; first_wr = -1; fd_cnt = 0; fd_cyc = -1; fd_bad = 0;
        eov_cnt = 0; eov_cyc = -1; wr_stall = 0; rdy_stall = 0; idle_nz = 0; busy_cnt = 0; pix_idx = 0;
        got.delete();
        bus.pix_valid = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            bus.stall_out             = (stall_mode == 1) && (c % 2 == 1);
            bus.encoder_vip_ctrl_busy = (c >= 1) && (c <= busy_last);
            bus.stop                  = (c == stop_cyc);
            bus.pix_data              = BASE + 24'(pix_idx);
            #1;
            if (bus.vip_ctrl_valid_out) begin ctrl_cnt++; ctrl_cyc = c; end
            if (bus.write) begin
                if (beats == 0) first_wr = c;
                got.push_back(bus.data_out);
                beats++;
                pix_idx++;
                if (bus.stall_out) wr_stall++;
            end
            if (bus.stall_out && bus.pix_ready) rdy_stall++;
            if (bus.frame_done) begin fd_cnt++; fd_cyc = c; if (!bus.write) fd_bad++; end
            if (bus.end_of_video_out) begin eov_cnt++; eov_cyc = c; end
            if (!bus.busy && bus.data_out != '0) idle_nz++;
            if (bus.busy) busy_cnt++;
            last_busy = bus.busy;
            last_rdy  = bus.cfg_ready;
            @(negedge clk);
        end
        bus.stall_out = 1'b0; bus.encoder_vip_ctrl_busy = 1'b0; bus.stop = 1'b0; bus.pix_valid = 1'b0;
    endtask

    // Called and returns at a negedge; the config is presented for exactly one cycle.
    task automatic offer_cfg(input logic [15:0] w, input logic [15:0] h, input logic [3:0] il);
        bus.cfg_valid = 1'b1; bus.cfg_width = w; bus.cfg_height = h; bus.cfg_interlaced = il;
        #1;
        tests++; if (bus.cfg_ready !== 1'b1) begin fails++; $display("FAIL offer_cfg_ready got=%0b exp=1", bus.cfg_ready); end
        @(negedge clk);
        bus.cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.cfg_valid = 1'b0; bus.cfg_width = '0; bus.cfg_height = '0; bus.cfg_interlaced = '0;
        bus.stop = 1'b0; bus.stall_out = 1'b0; bus.encoder_vip_ctrl_busy = 1'b0;
        bus.pix_valid = 1'b1; bus.pix_data = 24'h123456;
        #1;
        tests++; if (bus.write !== 1'b0)     begin fails++; $display("FAIL rst_write got=%0b exp=0", bus.write); end
        tests++; if (bus.data_out !== 24'h0) begin fails++; $display("FAIL rst_data got=%h exp=0", bus.data_out); end
        tests++; if (bus.pix_ready !== 1'b0) begin fails++; $display("FAIL rst_pix_ready got=%0b exp=0", bus.pix_ready); end
        tests++; if (bus.busy !== 1'b0)      begin fails++; $display("FAIL rst_busy got=%0b exp=0", bus.busy); end
        tests++; if ({bus.width_out, bus.height_out, bus.interlaced_out} !== 36'h0)
            begin fails++; $display("FAIL rst_cfg_out got=%h exp=0", {bus.width_out, bus.height_out, bus.interlaced_out}); end
        tests++; if ({bus.vip_ctrl_valid_out, bus.end_of_video_out, bus.frame_done, bus.cfg_error} !== 4'b0)
            begin fails++; $display("FAIL rst_pulses got=%b exp=0000", {bus.vip_ctrl_valid_out, bus.end_of_video_out, bus.frame_done, bus.cfg_error}); end
        @(negedge clk); @(negedge clk);
        rst = 1'b0; bus.pix_valid = 1'b0;
        #1;
        tests++; if (bus.cfg_ready !== 1'b1) begin fails++; $display("FAIL rst_cfg_ready got=%0b exp=1", bus.cfg_ready); end
        @(negedge clk);
    endtask

    // 4x2: request at c0, two settle cycles, beats c3..c10, frame_done on c10, idle from c11.
    task automatic test_basic_frame();
        offer_cfg(16'd4, 16'd2, 4'd0);
        watch(13, 0, 0, -1);
        tests++; if (ctrl_cnt !== 1)  begin fails++; $display("FAIL t1_ctrl_cnt got=%0d exp=1", ctrl_cnt); end
        tests++; if (ctrl_cyc !== 0)  begin fails++; $display("FAIL t1_ctrl_cyc got=%0d exp=0", ctrl_cyc); end
        tests++; if (beats !== 8)     begin fails++; $display("FAIL t1_beats got=%0d exp=8", beats); end
        tests++; if (first_wr !== 3)  begin fails++; $display("FAIL t1_first_wr got=%0d exp=3", first_wr); end
        tests++; if (fd_cnt !== 1 || fd_cyc !== 10 || fd_bad !== 0)
            begin fails++; $display("FAIL t1_frame_done got cnt=%0d cyc=%0d bad=%0d exp 1/10/0", fd_cnt, fd_cyc, fd_bad); end
        for (int k = 0; k < beats; k++) begin
            tests++; if (got[k] !== BASE + 24'(k)) begin fails++; $display("FAIL t1_data[%0d] got=%h exp=%h", k, got[k], BASE + 24'(k)); end
        end
        tests++; if (eov_cnt !== 0)   begin fails++; $display("FAIL t1_eov got=%0d exp=0", eov_cnt); end
        tests++; if (idle_nz !== 0)   begin fails++; $display("FAIL t1_idle_data got=%0d exp=0", idle_nz); end
        tests++; if (last_busy !== 1'b0 || last_rdy !== 1'b1)
            begin fails++; $display("FAIL t1_end_idle got busy=%0b rdy=%0b exp 0/1", last_busy, last_rdy); end
        tests++; if (bus.width_out !== 16'd4 || bus.height_out !== 16'd2)
            begin fails++; $display("FAIL t1_latched got=%0dx%0d exp=4x2", bus.width_out, bus.height_out); end
    endtask

    // 3x1 with stall high on odd cycles: stream starts c3 (stalled), beats on c4, c6, c8.
    task automatic test_stall();
        offer_cfg(16'd3, 16'd1, 4'd0);
        watch(12, 1, 0, -1);
        tests++; if (beats !== 3)     begin fails++; $display("FAIL t2_beats got=%0d exp=3", beats); end
        tests++; if (wr_stall !== 0)  begin fails++; $display("FAIL t2_write_in_stall got=%0d exp=0", wr_stall); end
        tests++; if (rdy_stall !== 0) begin fails++; $display("FAIL t2_ready_in_stall got=%0d exp=0", rdy_stall); end
        tests++; if (first_wr !== 4)  begin fails++; $display("FAIL t2_first_wr got=%0d exp=4", first_wr); end
        tests++; if (fd_cyc !== 8)    begin fails++; $display("FAIL t2_fd_cyc got=%0d exp=8", fd_cyc); end
        for (int k = 0; k < beats; k++) begin
            tests++; if (got[k] !== BASE + 24'(k)) begin fails++; $display("FAIL t2_data[%0d] got=%h exp=%h", k, got[k], BASE + 24'(k)); end
        end
    endtask

    // Encoder busy c1..c10, low from c11: stream starts c12; 2x1 ends on c13.
    task automatic test_encoder_busy();
        offer_cfg(16'd2, 16'd1, 4'd0);
        watch(16, 0, 10, -1);
        tests++; if (first_wr !== 12) begin fails++; $display("FAIL t3_first_wr got=%0d exp=12", first_wr); end
        tests++; if (beats !== 2)     begin fails++; $display("FAIL t3_beats got=%0d exp=2", beats); end
        tests++; if (fd_cyc !== 13)   begin fails++; $display("FAIL t3_fd_cyc got=%0d exp=13", fd_cyc); end
    endtask

    // Stop pulse on c5 (mid-frame): frame completes on c10, EOV on c11, idle after.
    task automatic test_stop();
        offer_cfg(16'd4, 16'd2, 4'd3);
        watch(14, 0, 0, 5);
        tests++; if (beats !== 8)     begin fails++; $display("FAIL t4_beats got=%0d exp=8", beats); end
        tests++; if (fd_cyc !== 10)   begin fails++; $display("FAIL t4_fd_cyc got=%0d exp=10", fd_cyc); end
        tests++; if (eov_cnt !== 1 || eov_cyc !== 11)
            begin fails++; $display("FAIL t4_eov got cnt=%0d cyc=%0d exp 1/11", eov_cnt, eov_cyc); end
        tests++; if (last_busy !== 1'b0 || last_rdy !== 1'b1)
            begin fails++; $display("FAIL t4_end_idle got busy=%0b rdy=%0b exp 0/1", last_busy, last_rdy); end
        tests++; if (bus.interlaced_out !== 4'd3) begin fails++; $display("FAIL t4_interlaced got=%0d exp=3", bus.interlaced_out); end
    endtask

    // Zero-sized configs are refused; a 1x1 frame afterwards is a single beat.
    task automatic test_bad_cfg();
        bus.cfg_valid = 1'b1; bus.cfg_width = 16'd0; bus.cfg_height = 16'd5;
        #1;
        tests++; if (bus.cfg_error !== 1'b1) begin fails++; $display("FAIL t5_err_w0 got=%0b exp=1", bus.cfg_error); end
        @(negedge clk);
        bus.cfg_width = 16'd3; bus.cfg_height = 16'd0;
        #1;
        tests++; if (bus.cfg_error !== 1'b1) begin fails++; $display("FAIL t5_err_h0 got=%0b exp=1", bus.cfg_error); end
        @(negedge clk);
        bus.cfg_valid = 1'b0;
        #1;
        tests++; if (bus.cfg_error !== 1'b0) begin fails++; $display("FAIL t5_err_clear got=%0b exp=0", bus.cfg_error); end
        @(negedge clk);
        watch(4, 0, 0, -1);
        tests++; if (ctrl_cnt !== 0 || busy_cnt !== 0)
            begin fails++; $display("FAIL t5_stayed_idle got ctrl=%0d busy=%0d exp 0/0", ctrl_cnt, busy_cnt); end
        offer_cfg(16'd1, 16'd1, 4'd0);
        watch(8, 0, 0, -1);
        tests++; if (beats !== 1 || first_wr !== 3 || fd_cyc !== 3)
            begin fails++; $display("FAIL t5_1x1 got beats=%0d wr=%0d fd=%0d exp 1/3/3", beats, first_wr, fd_cyc); end
        tests++; if (ctrl_cnt !== 1) begin fails++; $display("FAIL t5_ctrl got=%0d exp=1", ctrl_cnt); end
    endtask

    // Reset after beat 3 of a 4x2 frame, then a clean 2x2 frame.
    task automatic test_mid_reset();
        int eov_seen;
        offer_cfg(16'd4, 16'd2, 4'd0);
        watch(6, 0, 0, -1);
        tests++; if (beats !== 3) begin fails++; $display("FAIL t6_pre_beats got=%0d exp=3", beats); end
        bus.pix_valid = 1'b1;
        rst = 1'b1;
        #1;
        tests++; if ({bus.write, bus.pix_ready, bus.busy, bus.frame_done, bus.vip_ctrl_valid_out} !== 5'b0)
            begin fails++; $display("FAIL t6_rst_outs got=%b exp=00000", {bus.write, bus.pix_ready, bus.busy, bus.frame_done, bus.vip_ctrl_valid_out}); end
        tests++; if (bus.data_out !== 24'h0 || bus.width_out !== 16'd0)
            begin fails++; $display("FAIL t6_rst_data got data=%h w=%0d exp 0/0", bus.data_out, bus.width_out); end
        eov_seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 2) begin rst = 1'b0; bus.pix_valid = 1'b0; end
            #1;
            if (bus.end_of_video_out) eov_seen++;
        end
        tests++; if (eov_seen !== 0) begin fails++; $display("FAIL t6_no_eov got=%0d exp=0", eov_seen); end
        @(negedge clk);
        offer_cfg(16'd2, 16'd2, 4'd0);
        watch(10, 0, 0, -1);
        tests++; if (beats !== 4 || first_wr !== 3 || fd_cyc !== 6)
            begin fails++; $display("FAIL t6_2x2 got beats=%0d wr=%0d fd=%0d exp 4/3/6", beats, first_wr, fd_cyc); end
        tests++; if (eov_cnt !== 0 || last_busy !== 1'b0)
            begin fails++; $display("FAIL t6_end got eov=%0d busy=%0b exp 0/0", eov_cnt, last_busy); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic_frame();
        test_stall();
        test_encoder_busy();
        test_stop();
        test_bad_cfg();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alt_vipvfr131_common_output_sequencer.md
Name: alt_vipvfr131_common_output_sequencer

Overview:
Frame-level controller for the VIP flow-control output stage. It accepts a per-frame configuration (width, height, interlace), issues one control-packet request, waits for the encoder to finish that packet, and then streams exactly width*height pixel beats from an upstream pixel source using the stall/write convention. Stop requests take effect at the next frame boundary and end with an end-of-video pulse. It sits between the frame reader's pixel FIFO/config registers and the flow-control output block.

Parameters:
BITS_PER_SYMBOL, 8, bits per colour symbol
SYMBOLS_PER_BEAT, 3, symbols per beat; one beat carries one pixel
CTRL_SETTLE_CYCLES, 2, minimum cycles spent in WAIT_CTRL before encoder_vip_ctrl_busy is trusted (range 1..15)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active high
cfg_valid  in  1  new frame configuration offered
cfg_ready  out  1  sequencer idle; configuration is accepted on cfg_valid & cfg_ready
cfg_width  in  16  active pixels per line
cfg_height  in  16  lines per frame or field
cfg_interlaced  in  4  interlace code, passed through unchanged
cfg_error  out  1  one-cycle pulse when a configuration with zero width or height is offered
stop  in  1  request end of video; level or pulse, latched internally
pix_data  in  BITS_PER_SYMBOL*SYMBOLS_PER_BEAT  upstream pixel
pix_valid  in  1  upstream pixel available
pix_ready  out  1  pixel consumed this cycle when pix_valid is also high
data_out  out  BITS_PER_SYMBOL*SYMBOLS_PER_BEAT  pixel to the flow-control output
width_out  out  16  latched width
height_out  out  16  latched height
interlaced_out  out  4  latched interlace code
vip_ctrl_valid_out  out  1  control-packet request pulse
end_of_video_out  out  1  end-of-video pulse
write  out  1  beat valid toward the flow-control output
stall_out  in  1  downstream stall
encoder_vip_ctrl_busy  in  1  encoder is sending a control packet
busy  out  1  state is not IDLE
frame_done  out  1  one-cycle pulse on the last beat of a frame

Behaviour:
- Reset values: all outputs 0; width_out, height_out and interlaced_out are 0; state is IDLE; counters are 0; stop_pending is 0.
- Reset is asynchronous. Asserting it mid-frame aborts the frame immediately. No end-of-video is generated for the aborted frame.
- stop_pending is set when stop is high in any cycle. It is cleared on entry to EOV.
- IDLE:
  - cfg_ready is 1.
  - If stop_pending or stop is high: go to EOV. This has priority over cfg_valid.
  - Else, on cfg_valid with width != 0 and height != 0: latch width, height and interlaced into the *_out registers and go to SEND_CTRL.
  - Else, on cfg_valid with width == 0 or height == 0: pulse cfg_error for one cycle and stay in IDLE.
- SEND_CTRL:
  - vip_ctrl_valid_out is 1 for exactly one cycle. The flow-control output holds the request if the encoder is busy.
  - Next state is WAIT_CTRL and the settle counter loads CTRL_SETTLE_CYCLES-1.
- WAIT_CTRL:
  - The settle counter decrements to 0.
  - Once it reaches 0 and encoder_vip_ctrl_busy is 0, go to STREAM.
  - Pixel and line counters are cleared here.
- STREAM:
  - pix_ready = ~stall_out.
  - write = pix_valid & ~stall_out, combinational with zero latency.
  - data_out = pix_data.
  - On each write: x increments; at x == width-1, x wraps to 0 and y increments.
  - On the write where x == width-1 and y == height-1: pulse frame_done the same cycle. Then go to EOV if stop_pending or stop is high, else go to IDLE.
  - stall_out or ~pix_valid holds the counters unchanged.
  - Width 1 and height 1 is legal: the frame is one beat.
- EOV:
  - end_of_video_out is 1 for one cycle, then go to IDLE.
  - Outside EOV, end_of_video_out is 0.
- Outside STREAM, write and pix_ready are 0 and data_out is 0.
- Counters are 16-bit. Comparisons use latched width-1 and height-1; these cannot underflow because zero dimensions are rejected.
- cfg_* inputs are ignored outside IDLE. The latched configuration is stable for the whole frame.
- busy = (state != IDLE).

Decomposition:
- Shared package:
  - state enum IDLE/SEND_CTRL/WAIT_CTRL/STREAM/EOV
  - 16-bit dimension type
  - 4-bit interlace type
  - settle-counter width constant
- Natural sub-module: alt_vipvfr131_common_xy_counter. It holds the x/y counters with enable, clear and the width/height limits, and outputs last_pixel and last_frame_beat.

Test Plan:
- Reset, then config 4x2 with interlaced=0 and pix_valid held 1 -> one vip_ctrl_valid_out pulse; exactly 8 write beats carrying data in input order; frame_done on beat 8; return to IDLE with cfg_ready=1.
- Config 3x1 with stall_out toggling every other cycle -> write never high while stall_out=1; exactly 3 beats; counters hold during stalls.
- encoder_vip_ctrl_busy held 1 for 10 cycles after the request -> no write until 1 cycle after busy falls and the settle count has expired.
- stop pulsed for 1 cycle in the middle of a 4x2 frame -> all 8 beats complete; frame_done pulses, then end_of_video_out pulses the next cycle, then IDLE.
- cfg_width=0 with cfg_valid -> cfg_error pulses 1 cycle, no vip_ctrl_valid_out, state stays IDLE; a following 1x1 config streams 1 beat.
- rst asserted at beat 3 of a 4x2 frame -> all outputs 0 immediately, no end_of_video_out; a new 2x2 config streams exactly 4 beats.
